// File: rtl/trap_commit_ctrl_pkg.sv
// Shared pipeline defines for the trap/ERTN commit controller.
// Contents: the FSM state encoding, the commit kind, the LoongArch ecode
// constants used by the controller and its users, and the default redirect PC.
package trap_commit_ctrl_pkg;

    localparam int unsigned ECODE_W = 6;
    localparam int unsigned ESUB_W  = 9;
    localparam int unsigned ADDR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef enum logic {
        KIND_EX   = 1'b0,
        KIND_ERTN = 1'b1
    } kind_t;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h1c00_0000;

endpackage

// File: rtl/trap_commit_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Ports: clk, reset, inc (count one event), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment unless already saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/trap_commit_ctrl.sv
// Exception / ERTN commit sequencer sitting after WB.
// Captures the trapping instruction's fields, issues one CSR commit strobe,
// holds flush + WB stall, then hands the redirect target to IF over valid/ready.
// Ports:
//   clk, reset                       clock, async active-high reset
//   wb_ex, ertn_flush                WB events (wb_ex wins when both are high)
//   wb_ecode/esubcode/pc/vaddr       trapping instruction fields from WB
//   csr_eentry, csr_era              redirect targets from the CSR file
//   redirect_ready                   IF accepts the redirect
//   wb_hold, flush                   pipeline stall / kill while busy
//   csr_ex_*, csr_ertn_we            CSR commit strobes and latched fields
//   redirect_valid, redirect_pc      redirect request to IF
//   ex_count                         saturating committed-exception count
//   busy_err                         sticky: WB event seen while not idle
module trap_commit_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] RESET_PC = trap_commit_ctrl_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_ex,
    input  logic             ertn_flush,
    input  logic [5:0]       wb_ecode,
    input  logic [8:0]       wb_esubcode,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_vaddr,
    input  logic [31:0]      csr_eentry,
    input  logic [31:0]      csr_era,
    input  logic             redirect_ready,
    output logic             wb_hold,
    output logic             flush,
    output logic             csr_ex_we,
    output logic [5:0]       csr_ex_ecode,
    output logic [8:0]       csr_ex_esubcode,
    output logic [31:0]      csr_ex_pc,
    output logic [31:0]      csr_ex_vaddr,
    output logic             csr_ertn_we,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] ex_count,
    output logic             busy_err
);

    import trap_commit_ctrl_pkg::state_t;
    import trap_commit_ctrl_pkg::kind_t;
    import trap_commit_ctrl_pkg::ST_IDLE;
    import trap_commit_ctrl_pkg::ST_COMMIT;
    import trap_commit_ctrl_pkg::ST_REDIRECT;
    import trap_commit_ctrl_pkg::KIND_EX;
    import trap_commit_ctrl_pkg::KIND_ERTN;

    state_t state_q;
    state_t state_nxt;
    kind_t  kind_q;
    kind_t  kind_nxt;
    logic   capture_c;
    logic   busy_evt_c;
    logic   ex_commit_c;

    // Next state, commit kind and event qualifiers.
    always_comb begin
        state_nxt  = state_q;
        kind_nxt   = kind_q;
        capture_c  = 1'b0;
        busy_evt_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_ex) begin
                    state_nxt = ST_COMMIT;
                    kind_nxt  = KIND_EX;
                    capture_c = 1'b1;
                end else if (ertn_flush) begin
                    state_nxt = ST_COMMIT;
                    kind_nxt  = KIND_ERTN;
                end
            end
            ST_COMMIT: begin
                state_nxt  = ST_REDIRECT;
                busy_evt_c = wb_ex | ertn_flush;
            end
            ST_REDIRECT: begin
                // redirect_valid is high for the whole state, so ready alone completes the handshake.
                if (redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
                busy_evt_c = wb_ex | ertn_flush;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        ex_commit_c = (state_q == ST_IDLE) && (state_nxt == ST_COMMIT) && (kind_nxt == KIND_EX);
    end

    // State register and registered outputs, each decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            kind_q          <= KIND_EX;
            wb_hold         <= 1'b0;
            flush           <= 1'b0;
            csr_ex_we       <= 1'b0;
            csr_ertn_we     <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= RESET_PC;
            csr_ex_ecode    <= '0;
            csr_ex_esubcode <= '0;
            csr_ex_pc       <= '0;
            csr_ex_vaddr    <= '0;
            busy_err        <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            kind_q         <= kind_nxt;
            wb_hold        <= (state_nxt != ST_IDLE);
            flush          <= (state_nxt != ST_IDLE);
            redirect_valid <= (state_nxt == ST_REDIRECT);
            csr_ex_we      <= ex_commit_c;
            csr_ertn_we    <= (state_q == ST_IDLE) && (state_nxt == ST_COMMIT)
                              && (kind_nxt == KIND_ERTN);
            busy_err       <= busy_err | busy_evt_c;
            if (capture_c) begin
                csr_ex_ecode    <= wb_ecode;
                csr_ex_esubcode <= wb_esubcode;
                csr_ex_pc       <= wb_pc;
                csr_ex_vaddr    <= wb_vaddr;
            end
            // Target is sampled from the CSR file during COMMIT and held through REDIRECT.
            if (state_q == ST_COMMIT) begin
                redirect_pc <= (kind_q == KIND_EX) ? csr_eentry : csr_era;
            end else if (state_nxt == ST_IDLE) begin
                redirect_pc <= RESET_PC;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_ex_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ex_commit_c),
        .count (ex_count)
    );

endmodule

// File: tb/tb_trap_commit_ctrl.sv
// Self-checking bench for trap_commit_ctrl: directed scenarios then random
// transactions, checked against a transaction-level expectation model.
module tb_trap_commit_ctrl;

    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_ex = 1'b0;
    logic        ertn_flush = 1'b0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_vaddr = '0;
    logic [31:0] csr_eentry = '0;
    logic [31:0] csr_era = '0;
    logic        redirect_ready = 1'b0;

    logic        wb_hold, flush, csr_ex_we, csr_ertn_we, redirect_valid, busy_err;
    logic [5:0]  csr_ex_ecode;
    logic [8:0]  csr_ex_esubcode;
    logic [31:0] csr_ex_pc, csr_ex_vaddr, redirect_pc;
    logic [15:0] ex_count;

    logic        s_wb_hold, s_flush, s_csr_ex_we, s_csr_ertn_we, s_redirect_valid, s_busy_err;
    logic [5:0]  s_csr_ex_ecode;
    logic [8:0]  s_csr_ex_esubcode;
    logic [31:0] s_csr_ex_pc, s_csr_ex_vaddr, s_redirect_pc;
    logic [1:0]  s_ex_count;

    int total = 0;
    int bad   = 0;
    int n_ex  = 0;
    logic exp_busy = 1'b0;

    always #5 clk = ~clk;

    trap_commit_ctrl #(.CNT_W(16), .RESET_PC(RPC)) u_dut (
        .clk(clk), .reset(reset), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .redirect_ready(redirect_ready),
        .wb_hold(wb_hold), .flush(flush), .csr_ex_we(csr_ex_we),
        .csr_ex_ecode(csr_ex_ecode), .csr_ex_esubcode(csr_ex_esubcode),
        .csr_ex_pc(csr_ex_pc), .csr_ex_vaddr(csr_ex_vaddr), .csr_ertn_we(csr_ertn_we),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ex_count(ex_count), .busy_err(busy_err)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    trap_commit_ctrl #(.CNT_W(2), .RESET_PC(RPC)) u_sat (
        .clk(clk), .reset(reset), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .redirect_ready(redirect_ready),
        .wb_hold(s_wb_hold), .flush(s_flush), .csr_ex_we(s_csr_ex_we),
        .csr_ex_ecode(s_csr_ex_ecode), .csr_ex_esubcode(s_csr_ex_esubcode),
        .csr_ex_pc(s_csr_ex_pc), .csr_ex_vaddr(s_csr_ex_vaddr), .csr_ertn_we(s_csr_ertn_we),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .ex_count(s_ex_count), .busy_err(s_busy_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, ".ex_count"}, 64'(ex_count), 64'(sat(n_ex, 16)));
        check({tag, ".sat_count"}, 64'(s_ex_count), 64'(sat(n_ex, 2)));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".flush"}, 64'(flush), 64'd0);
        check({tag, ".wb_hold"}, 64'(wb_hold), 64'd0);
        check({tag, ".rvalid"}, 64'(redirect_valid), 64'd0);
        check({tag, ".ex_we"}, 64'(csr_ex_we), 64'd0);
        check({tag, ".ertn_we"}, 64'(csr_ertn_we), 64'd0);
        check({tag, ".rpc"}, 64'(redirect_pc), 64'(RPC));
        check({tag, ".busy_err"}, 64'(busy_err), 64'(exp_busy));
        check_counts(tag);
    endtask

    // One WB event followed by its full commit/redirect sequence.
    // delay = number of REDIRECT cycles with ready low before it is accepted.
    task automatic run_txn(input string tag, input logic ex, input logic ertn,
                           input logic [5:0] ec, input logic [8:0] esc,
                           input logic [31:0] pc, input logic [31:0] va,
                           input logic [31:0] ee, input logic [31:0] er,
                           input int delay, input bit inject, input bit rst_mid);
        logic [31:0] target;
        target = ex ? ee : er;

        @(negedge clk);
        wb_ex = ex; ertn_flush = ertn;
        wb_ecode = ec; wb_esubcode = esc; wb_pc = pc; wb_vaddr = va;
        csr_eentry = ee; csr_era = er; redirect_ready = 1'($urandom);

        // COMMIT cycle
        @(negedge clk);
        wb_ex = 1'b0; ertn_flush = 1'b0;
        wb_ecode = 6'($urandom); wb_esubcode = 9'($urandom);
        wb_pc = $urandom; wb_vaddr = $urandom;
        if (ex) n_ex++;
        check({tag, ".c.ex_we"}, 64'(csr_ex_we), 64'(ex));
        check({tag, ".c.ertn_we"}, 64'(csr_ertn_we), 64'(!ex));
        check({tag, ".c.flush"}, 64'(flush), 64'd1);
        check({tag, ".c.wb_hold"}, 64'(wb_hold), 64'd1);
        check({tag, ".c.rvalid"}, 64'(redirect_valid), 64'd0);
        check_counts({tag, ".c"});
        if (ex) begin
            check({tag, ".c.ecode"}, 64'(csr_ex_ecode), 64'(ec));
            check({tag, ".c.esub"}, 64'(csr_ex_esubcode), 64'(esc));
            check({tag, ".c.pc"}, 64'(csr_ex_pc), 64'(pc));
            check({tag, ".c.vaddr"}, 64'(csr_ex_vaddr), 64'(va));
            check({tag, ".c.sat_vaddr"}, 64'(s_csr_ex_vaddr), 64'(va));
        end
        redirect_ready = 1'b0;

        // REDIRECT cycles
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            wb_ex = 1'b0; ertn_flush = 1'b0;
            csr_eentry = $urandom; csr_era = $urandom;
            check({tag, ".r.rvalid"}, 64'(redirect_valid), 64'd1);
            check({tag, ".r.rpc"}, 64'(redirect_pc), 64'(target));
            check({tag, ".r.flush"}, 64'(flush), 64'd1);
            check({tag, ".r.wb_hold"}, 64'(wb_hold), 64'd1);
            check({tag, ".r.ex_we"}, 64'(csr_ex_we), 64'd0);
            check({tag, ".r.ertn_we"}, 64'(csr_ertn_we), 64'd0);
            check({tag, ".r.busy_err"}, 64'(busy_err), 64'(exp_busy));
            check_counts({tag, ".r"});
            if (rst_mid && i == 0) begin
                #2 reset = 1'b1;
                #1;
                n_ex = 0; exp_busy = 1'b0;
                check_idle({tag, ".rst"});
                check({tag, ".rst.ex_pc"}, 64'(csr_ex_pc), 64'd0);
                check({tag, ".rst.ecode"}, 64'(csr_ex_ecode), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_idle({tag, ".post_rst"});
                end
                return;
            end
            if (inject && i == 0) begin
                wb_ex = 1'b1;
                ertn_flush = 1'($urandom);
                exp_busy = 1'b1;
            end
            redirect_ready = (i == delay);
        end

        @(negedge clk);
        wb_ex = 1'b0; ertn_flush = 1'b0; redirect_ready = 1'b0;
        check_idle({tag, ".idle"});
    endtask

    initial begin
        // Reset state
        #12;
        check_idle("reset");
        check("reset.ex_vaddr", 64'(csr_ex_vaddr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        run_txn("syscall", 1'b1, 1'b0, 6'h0B, 9'h0, 32'h1c00_0040, 32'h0,
                32'h1c00_8000, 32'h1234_5678, 0, 1'b0, 1'b0);
        run_txn("ertn", 1'b0, 1'b1, 6'h3F, 9'h1FF, 32'hdead_beef, 32'h0,
                32'h1c00_8000, 32'h1c00_0044, 3, 1'b0, 1'b0);
        run_txn("simul", 1'b1, 1'b1, 6'h0D, 9'h005, 32'h1c00_0100, 32'h0,
                32'h1c00_9000, 32'h1c00_0200, 1, 1'b0, 1'b0);
        run_txn("busy", 1'b1, 1'b0, 6'h0C, 9'h0, 32'h1c00_0300, 32'h0,
                32'h1c00_8000, 32'h0, 2, 1'b1, 1'b0);
        run_txn("rst_mid", 1'b1, 1'b0, 6'h08, 9'h0, 32'h1c00_0400, 32'h1c00_0401,
                32'h1c00_8000, 32'h0, 2, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            run_txn("ale_sat", 1'b1, 1'b0, 6'h09, 9'h0, 32'h1c00_0500 + 32'(j), 32'h3,
                    32'h1c00_8000, 32'h0, j % 2, 1'b0, 1'b0);
        end

        for (int j = 0; j < 25; j++) begin
            logic ex, er;
            ex = 1'($urandom);
            er = ex ? 1'($urandom) : 1'b1;
            run_txn("rand", ex, er, 6'($urandom), 9'($urandom), $urandom, $urandom,
                    $urandom, $urandom, int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 3) == 0), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                check_idle("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_commit_ctrl.md
Name: trap_commit_ctrl

Overview:
- Sequences exception and ERTN commit after the WB stage.
- Captures the trapping instruction's cause, PC and vaddr from WB, then issues exactly one CSR commit pulse.
- Holds a pipeline-wide flush, then hands a redirect PC to IF through a valid/ready handshake.
- While busy, stalls WB, and it keeps a saturating exception counter for debug.

Parameters:
- CNT_W, 16, width of the saturating committed-exception counter.
- RESET_PC, 32'h1c000000, value driven on redirect_pc while idle.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wb_ex  in  1  WB holds a valid exception instruction (not ERTN)
- ertn_flush  in  1  WB holds a valid ERTN
- wb_ecode  in  6  exception code from WB
- wb_esubcode  in  9  exception subcode from WB
- wb_pc  in  32  PC of the WB instruction
- wb_vaddr  in  32  faulting address for ALE/ADEF
- csr_eentry  in  32  current EENTRY value from the CSR file
- csr_era  in  32  current ERA value from the CSR file
- redirect_ready  in  1  IF accepts the redirect this cycle
- wb_hold  out  1  forces WB_allow low while the controller is busy
- flush  out  1  kills all stage valids
- csr_ex_we  out  1  one-cycle exception commit strobe to the CSR file
- csr_ex_ecode  out  6  latched ecode
- csr_ex_esubcode  out  9  latched esubcode
- csr_ex_pc  out  32  latched PC, to be written into ERA
- csr_ex_vaddr  out  32  latched vaddr, to be written into BADV
- csr_ertn_we  out  1  one-cycle ERTN commit strobe (restore CRMD from PRMD)
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  32  target PC
- ex_count  out  CNT_W  committed exceptions, saturating
- busy_err  out  1  sticky: a WB event arrived while the controller was not IDLE

Behaviour:
- Reset is asynchronous: the FSM goes to IDLE and every output goes to 0, except redirect_pc = RESET_PC. Latched fields and ex_count clear to 0.
- State machine has three states: IDLE, COMMIT, REDIRECT. The 2-bit state is registered.
- IDLE:
  - On wb_ex: latch ecode, esubcode, pc and vaddr, set kind = EX, next state COMMIT.
  - Else on ertn_flush: set kind = ERTN, next state COMMIT.
  - wb_ex has priority if both are high in the same cycle; in that case kind = EX and no ertn strobe is issued.
- COMMIT (exactly 1 cycle):
  - flush = 1, wb_hold = 1.
  - kind = EX: csr_ex_we = 1, and ex_count increments unless it is all-ones.
  - kind = ERTN: csr_ertn_we = 1.
  - Target latched this cycle: csr_eentry for EX, csr_era for ERTN. ERTN does not modify ERA.
  - Next state: REDIRECT.
- REDIRECT:
  - flush = 1, wb_hold = 1, redirect_valid = 1, redirect_pc = latched target.
  - redirect_pc stays stable until the handshake completes.
  - When redirect_valid && redirect_ready: go to IDLE next cycle, with redirect_valid = 0 in that cycle.
  - No timeout: the controller waits indefinitely.
- Latency: an event sampled at edge T gives csr_*_we high in T+1 and redirect_valid from T+2. If ready is already high at T+2, the controller is IDLE again at T+3.
- csr_ex_* data outputs are registered and hold their last values outside COMMIT. Consumers qualify them only with csr_ex_we.
- Any wb_ex or ertn_flush seen in COMMIT or REDIRECT is ignored and sets busy_err. busy_err clears only on reset.
- flush, wb_hold and redirect_valid are decoded directly from state registers, with no combinational path from inputs. The only input-to-output path is none: redirect_ready affects only the next state.
- Reset asserted mid-sequence (including while redirect_valid is high) aborts immediately; no CSR strobe is issued afterwards.

Decomposition:
- Shared package (pipeline defines file):
  - state encodings ST_IDLE = 0, ST_COMMIT = 1, ST_REDIRECT = 2
  - ecode constants ECODE_INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D
  - RESET_PC
- No sub-module, except that the saturating counter may be a small sat_counter #(CNT_W).

Test Plan:
- SYSCALL commit:
  - Stimulus: wb_ex = 1, ecode = 0x0B, pc = 0x1c000040 for 1 cycle; csr_eentry = 0x1c008000; redirect_ready = 1.
  - Response: csr_ex_we pulses at T+1 with pc = 0x1c000040; redirect_valid at T+2 with pc 0x1c008000; IDLE at T+3; ex_count = 1.
- ERTN commit:
  - Stimulus: ertn_flush = 1; csr_era = 0x1c000044; redirect_ready held 0 for 3 cycles.
  - Response: csr_ertn_we pulses once, csr_ex_we never; redirect_valid held with pc 0x1c000044 for 4 cycles; flush high throughout.
- Simultaneous events:
  - Stimulus: wb_ex = 1 and ertn_flush = 1 in the same cycle, ecode = 0x0D.
  - Response: only csr_ex_we pulses with ecode 0x0D; redirect_pc = eentry.
- Event while busy:
  - Stimulus: wb_ex pulsed during REDIRECT.
  - Response: no second commit; busy_err = 1 and stays set; ex_count unchanged.
- Reset mid-redirect:
  - Stimulus: assert reset asynchronously (between clock edges) while redirect_valid = 1.
  - Response: all outputs 0 immediately (redirect_pc = 0x1c000000); ex_count = 0.
- Counter saturation:
  - Stimulus: CNT_W = 2, four ALE exceptions (ecode 0x09, vaddr 0x3).
  - Response: ex_count reads 3 after the third and fourth commits; csr_ex_vaddr = 0x3.
